mult_key_loader: RTL and testbench

//  Upstream stage of the locked 8x8 array multiplier. Loads the 32-bit unlock key

---
 rtl/mult_key_loader_if.sv | 34 +++
 rtl/mult_key_loader.sv | 161 ++++++++++++++++
 tb/tb_mult_key_loader.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_key_loader_if.sv
// Key-load and operand handshake bundle between upstream, the key loader and the multiplier.
interface mult_key_loader_if #(
    parameter int KEY_W = 32,
    parameter int OP_W  = 8
);
    logic             key_start_i;
    logic             key_bit_i;
    logic             key_valid_i;
    logic             key_ready_o;
    logic             key_loaded_o;
    logic             key_done_o;
    logic             key_err_o;
    logic [KEY_W-1:0] keyinput_o;
    logic [OP_W-1:0]  op1_i;
    logic [OP_W-1:0]  op2_i;
    logic             op_valid_i;
    logic             op_ready_o;
    logic [OP_W-1:0]  op1_o;
    logic [OP_W-1:0]  op2_o;
    logic             op_valid_o;
    logic             op_ready_i;

    modport slave (
        input  key_start_i, key_bit_i, key_valid_i, op1_i, op2_i, op_valid_i, op_ready_i,
        output key_ready_o, key_loaded_o, key_done_o, key_err_o, keyinput_o,
               op_ready_o, op1_o, op2_o, op_valid_o
    );

    modport master (
        output key_start_i, key_bit_i, key_valid_i, op1_i, op2_i, op_valid_i, op_ready_i,
        input  key_ready_o, key_loaded_o, key_done_o, key_err_o, keyinput_o,
               op_ready_o, op1_o, op2_o, op_valid_o
    );
endinterface

// File: rtl/mult_key_loader.sv
// Serial key loader with even-parity check (commit 2 cycles after parity beat) and a 1-cycle operand register;
// key commit stalls while an operand is held downstream. MULT_KEY_LOCKOUT_EN adds lockout after MAX_FAIL bad loads.
module mult_key_loader #(
    parameter int KEY_W    = 32,
    parameter int OP_W     = 8
`ifdef MULT_KEY_LOCKOUT_EN
    ,
    parameter int MAX_FAIL = 3
`endif
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mult_key_loader_if.slave bus
);
    localparam int CNT_W = $clog2(KEY_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_W - 1);

    typedef enum logic [2:0] {IDLE, SHIFT, PARITY, COMMIT, FAIL} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [KEY_W-1:0] r_shadow;
    logic [KEY_W-1:0] w_shadow;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count;
    logic [KEY_W-1:0] r_keyinput;
    logic             r_key_loaded;
    logic             r_key_done;
    logic             r_key_err;
    logic [OP_W-1:0]  r_op1;
    logic [OP_W-1:0]  r_op2;
    logic             r_op_valid;
    logic             w_key_ready;
    logic             w_beat;
    logic             w_commit;
    logic             w_fail;
    logic             w_locked;
    logic             w_lock_now;
    logic             w_op_ready;
    logic             w_op_acc;

`ifdef MULT_KEY_LOCKOUT_EN
    localparam int FC_W = $clog2(MAX_FAIL + 1);
    logic [FC_W-1:0] r_fail_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fail_cnt <= '0;
        end else if (w_fail && !w_locked) begin
            r_fail_cnt <= r_fail_cnt + FC_W'(1);
        end
    end

    assign w_locked   = (r_fail_cnt == FC_W'(MAX_FAIL));
    assign w_lock_now = w_fail && (r_fail_cnt == FC_W'(MAX_FAIL - 1));
`else
    assign w_locked   = 1'b0;
    assign w_lock_now = 1'b0;
`endif

    assign w_key_ready = (r_state == SHIFT) || (r_state == PARITY);
    assign w_beat      = bus.key_valid_i && w_key_ready;

    always_comb begin
        w_next   = r_state;
        w_shadow = r_shadow;
        w_count  = r_count;
        w_commit = 1'b0;
        w_fail   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.key_start_i && !w_locked) begin
                    w_next   = SHIFT;
                    w_shadow = '0;
                    w_count  = '0;
                end
            end
            SHIFT: begin
                if (bus.key_start_i) begin
                    w_shadow = '0;
                    w_count  = '0;
                end else if (w_beat) begin
                    w_shadow = {r_shadow[KEY_W-2:0], bus.key_bit_i};
                    w_count  = r_count + CNT_W'(1);
                    if (r_count == LAST_BIT) begin
                        w_next = PARITY;
                    end
                end
            end
            PARITY: begin
                if (bus.key_start_i) begin
                    w_next   = SHIFT;
                    w_shadow = '0;
                    w_count  = '0;
                end else if (w_beat) begin
                    w_next = ((^r_shadow) ^ bus.key_bit_i) ? FAIL : COMMIT;
                end
            end
            COMMIT: begin
                // Key must not change under an operand pair the multiplier is still using.
                if (!r_op_valid) begin
                    w_commit = 1'b1;
                    w_next   = IDLE;
                end
            end
            FAIL: begin
                w_fail = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_op_ready = r_key_loaded && (r_state != COMMIT) && (!r_op_valid || bus.op_ready_i);
    assign w_op_acc   = bus.op_valid_i && w_op_ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_shadow     <= '0;
            r_count      <= '0;
            r_keyinput   <= '0;
            r_key_loaded <= 1'b0;
            r_key_done   <= 1'b0;
            r_key_err    <= 1'b0;
            r_op1        <= '0;
            r_op2        <= '0;
            r_op_valid   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_shadow   <= w_shadow;
            r_count    <= w_count;
            r_key_done <= w_commit;
            r_key_err  <= w_fail;
            if (w_commit) begin
                r_keyinput   <= r_shadow;
                r_key_loaded <= 1'b1;
            end else if (w_lock_now) begin
                r_keyinput   <= '0;
                r_key_loaded <= 1'b0;
            end
            if (w_op_acc) begin
                r_op1      <= bus.op1_i;
                r_op2      <= bus.op2_i;
                r_op_valid <= 1'b1;
            end else if (bus.op_ready_i) begin
                r_op_valid <= 1'b0;
            end
        end
    end

    assign bus.key_ready_o  = w_key_ready;
    assign bus.key_loaded_o = r_key_loaded;
    assign bus.key_done_o   = r_key_done;
    assign bus.key_err_o    = r_key_err;
    assign bus.keyinput_o   = r_keyinput;
    assign bus.op_ready_o   = w_op_ready;
    assign bus.op1_o        = r_op1;
    assign bus.op2_o        = r_op2;
    assign bus.op_valid_o   = r_op_valid;
endmodule

// File: tb/tb_mult_key_loader.sv
// Bench for mult_key_loader: directed key/operand scenarios plus a randomized run against a behavioural model.
module tb_mult_key_loader;
    localparam int MAXF = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic run_chk = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mult_key_loader_if #(.KEY_W(32), .OP_W(8)) bus ();

    mult_key_loader dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Behavioural model: a loading flag with a received-bit tally, plus a pending outcome.
    logic        m_loading;
    int          m_n;
    logic [31:0] m_acc;
    int          m_pend;   // 0 nothing, 1 commit waiting, 2 failure to report
    logic [31:0] m_key;
    logic        m_loaded, m_done, m_err, m_opv;
    logic [7:0]  m_op1, m_op2;
    int          m_fails;

`ifdef MULT_KEY_LOCKOUT_EN
    wire m_locked = (m_fails >= MAXF);
`else
    wire m_locked = 1'b0;
`endif
    wire m_op_ready = m_loaded && (m_pend != 1) && (!m_opv || bus.op_ready_i);
    wire m_beat     = bus.key_valid_i && m_loading;
    wire m_op_acc   = bus.op_valid_i && m_op_ready;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_loading <= 1'b0; m_n <= 0; m_acc <= '0; m_pend <= 0;
            m_key <= '0; m_loaded <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
            m_opv <= 1'b0; m_op1 <= '0; m_op2 <= '0; m_fails <= 0;
        end else begin
            m_done <= 1'b0;
            m_err  <= 1'b0;
            if (m_pend == 1) begin
                if (!m_opv) begin
                    m_key <= m_acc; m_loaded <= 1'b1; m_done <= 1'b1; m_pend <= 0;
                end
            end else if (m_pend == 2) begin
                m_err  <= 1'b1;
                m_pend <= 0;
`ifdef MULT_KEY_LOCKOUT_EN
                if (m_fails < MAXF) m_fails <= m_fails + 1;
                if (m_fails + 1 >= MAXF) begin
                    m_key <= '0; m_loaded <= 1'b0;
                end
`endif
            end else if (bus.key_start_i && !m_locked) begin
                m_loading <= 1'b1; m_n <= 0; m_acc <= '0;
            end else if (m_beat) begin
                if (m_n < 32) begin
                    m_acc <= {m_acc[30:0], bus.key_bit_i};
                    m_n   <= m_n + 1;
                end else begin
                    m_loading <= 1'b0;
                    m_pend    <= ((^m_acc) ^ bus.key_bit_i) ? 2 : 1;
                end
            end
            if (m_op_acc) begin
                m_opv <= 1'b1; m_op1 <= bus.op1_i; m_op2 <= bus.op2_i;
            end else if (bus.op_ready_i) begin
                m_opv <= 1'b0;
            end
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_chk && !rst) begin
            chk32("m.keyinput",   bus.keyinput_o,   m_key);
            chk1 ("m.key_loaded", bus.key_loaded_o, m_loaded);
            chk1 ("m.key_done",   bus.key_done_o,   m_done);
            chk1 ("m.key_err",    bus.key_err_o,    m_err);
            chk1 ("m.key_ready",  bus.key_ready_o,  m_loading);
            chk1 ("m.op_ready",   bus.op_ready_o,   m_op_ready);
            chk1 ("m.op_valid",   bus.op_valid_o,   m_opv);
            if (m_opv) begin
                chk32("m.op1", 32'(bus.op1_o), 32'(m_op1));
                chk32("m.op2", 32'(bus.op2_o), 32'(m_op2));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1: pulses key_start_i, then nbeats back-to-back beats (bit 32 is parity).
    task automatic send_key(input logic [31:0] k, input logic p, input int nbeats);
        bus.key_start_i = 1'b1;
        bus.key_valid_i = 1'b0;
        tick();
        bus.key_start_i = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            bus.key_valid_i = 1'b1;
            bus.key_bit_i   = (i < 32) ? k[31 - i] : p;
            tick();
        end
        bus.key_valid_i = 1'b0;
    endtask

    initial begin
        logic [31:0] k;
        bus.key_start_i = 1'b0; bus.key_bit_i = 1'b0; bus.key_valid_i = 1'b0;
        bus.op1_i = '0; bus.op2_i = '0; bus.op_valid_i = 1'b0; bus.op_ready_i = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        run_chk = 1'b1;

        // Reset values
        #1;
        chk32("rst.keyinput",  bus.keyinput_o,   32'h0);
        chk1 ("rst.loaded",    bus.key_loaded_o, 1'b0);
        chk1 ("rst.done",      bus.key_done_o,   1'b0);
        chk1 ("rst.err",       bus.key_err_o,    1'b0);
        chk1 ("rst.op_valid",  bus.op_valid_o,   1'b0);
        chk1 ("rst.key_ready", bus.key_ready_o,  1'b0);
        tick();

        // Bad parity from reset: error pulse, nothing committed, operands still blocked
        bus.op_ready_i = 1'b1;
        send_key(32'hA5A5_00FF, 1'b1, 33);
        chk1("bad.err_early", bus.key_err_o, 1'b0);
        tick();
        chk1 ("bad.err",      bus.key_err_o,    1'b1);
        chk32("bad.keyinput", bus.keyinput_o,   32'h0);
        chk1 ("bad.op_ready", bus.op_ready_o,   1'b0);
        tick();
        chk1 ("bad.err_1cyc", bus.key_err_o,    1'b0);

        // Good key: commit two cycles after the parity beat
        send_key(32'hA5A5_00FF, 1'b0, 33);
        chk1 ("good.done_early", bus.key_done_o, 1'b0);
        chk32("good.key_early",  bus.keyinput_o, 32'h0);
        tick();
        chk1 ("good.done",     bus.key_done_o,   1'b1);
        chk32("good.keyinput", bus.keyinput_o,   32'hA5A5_00FF);
        chk1 ("good.loaded",   bus.key_loaded_o, 1'b1);
        tick();
        chk1 ("good.done_1cyc", bus.key_done_o, 1'b0);

        // Full-throughput operand stream, 16 pairs starting at 13 x 11
        for (int i = 0; i < 16; i++) begin
            bus.op_valid_i = 1'b1;
            bus.op1_i = 8'(13 + i);
            bus.op2_i = 8'(11 + i);
            #1;
            chk1("thr.op_ready", bus.op_ready_o, 1'b1);
            @(posedge clk); #1;
            chk1 ("thr.op_valid", bus.op_valid_o, 1'b1);
            chk32("thr.op1", 32'(bus.op1_o), 32'(13 + i));
            chk32("thr.op2", 32'(bus.op2_o), 32'(11 + i));
        end
        bus.op_valid_i = 1'b0;
        tick();

        // Reload while an operand is held downstream: commit waits for consumption
        bus.op_ready_i = 1'b0;
        bus.op_valid_i = 1'b1; bus.op1_i = 8'h55; bus.op2_i = 8'h66;
        tick();
        bus.op_valid_i = 1'b0;
        k = 32'h1234_5678;
        send_key(k, ^k, 33);
        repeat (4) tick();
        chk32("hold.keyinput",  bus.keyinput_o,  32'hA5A5_00FF);
        chk1 ("hold.key_ready", bus.key_ready_o, 1'b0);
        chk1 ("hold.op_valid",  bus.op_valid_o,  1'b1);
        chk32("hold.op1",       32'(bus.op1_o),  32'h55);
        chk1 ("hold.op_ready",  bus.op_ready_o,  1'b0);
        bus.op_ready_i = 1'b1;
        tick();
        chk1 ("hold.drained",   bus.op_valid_o,  1'b0);
        chk32("hold.key_still", bus.keyinput_o,  32'hA5A5_00FF);
        tick();
        chk32("hold.keyinput2", bus.keyinput_o,  32'h1234_5678);
        chk1 ("hold.done",      bus.key_done_o,  1'b1);

        // Restart after 17 beats; only the second key is committed
        send_key(32'hFFFF_0000, 1'b0, 17);
        k = 32'hDEAD_BEEF;
        send_key(k, ^k, 33);
        tick();
        chk32("restart.keyinput", bus.keyinput_o, 32'hDEAD_BEEF);
        tick();

        // Asynchronous reset mid-load with an operand held
        bus.op_ready_i = 1'b0;
        bus.op_valid_i = 1'b1; bus.op1_i = 8'hC3; bus.op2_i = 8'h3C;
        tick();
        bus.op_valid_i = 1'b0;
        send_key(32'hCAFE_F00D, 1'b0, 10);
        #1 rst = 1'b1;
        #1;
        chk32("arst.keyinput",  bus.keyinput_o,   32'h0);
        chk1 ("arst.loaded",    bus.key_loaded_o, 1'b0);
        chk1 ("arst.op_valid",  bus.op_valid_o,   1'b0);
        chk32("arst.op1",       32'(bus.op1_o),   32'h0);
        chk1 ("arst.key_ready", bus.key_ready_o,  1'b0);
        tick();
        rst = 1'b0;
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            bus.key_start_i = ($urandom_range(0, 99) < 1);
            bus.key_valid_i = !bus.key_start_i && ($urandom_range(0, 3) != 0);
            bus.key_bit_i   = 1'($urandom_range(0, 1));
            bus.op_valid_i  = 1'($urandom_range(0, 1));
            bus.op1_i       = 8'($urandom);
            bus.op2_i       = 8'($urandom);
            bus.op_ready_i  = ($urandom_range(0, 9) < 7);
            tick();
        end
        bus.key_start_i = 1'b0; bus.key_valid_i = 1'b0; bus.op_valid_i = 1'b0; bus.op_ready_i = 1'b1;
        repeat (3) tick();

        // Repeated parity failures after a good key
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send_key(32'h1111_1111, 1'b0, 33);
        repeat (2) tick();
        for (int f = 0; f < MAXF; f++) begin
            send_key(32'h1111_1111, 1'b1, 33);
            repeat (2) tick();
        end
`ifdef MULT_KEY_LOCKOUT_EN
        chk32("lock.keyinput", bus.keyinput_o,   32'h0);
        chk1 ("lock.loaded",   bus.key_loaded_o, 1'b0);
        send_key(32'h0F0F_0F0F, 1'b0, 33);
        repeat (2) tick();
        chk32("lock.ignored",  bus.keyinput_o,   32'h0);
        chk1 ("lock.no_ready", bus.key_ready_o,  1'b0);
`else
        chk32("retry.keyinput", bus.keyinput_o,   32'h1111_1111);
        chk1 ("retry.loaded",   bus.key_loaded_o, 1'b1);
        send_key(32'h0F0F_0F0F, 1'b0, 33);
        repeat (2) tick();
        chk32("retry.newkey",   bus.keyinput_o,   32'h0F0F_0F0F);
`endif
        tick();
        run_chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
